acs_decay_mux: RTL and testbench
================================

ACS_DECAY_MUX -- requirements
Module: acs_decay_mux

Interface
REQ-001 SHALL have parameter ACS_BITS, default 8, accumulated-metric width.
REQ-002 SHALL have parameter NUM_STATES, default 4, trellis states per bank, range 2..16.
REQ-003 SHALL have parameter DECAY_BITS, default 8, decay-factor width.
REQ-004 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port symEn  input  1  input-valid strobe, one cycle per symbol.
REQ-007 SHALL have port symEnEven  input  1  bank select: 1 = 45 bank, 0 = 54 bank.
REQ-008 SHALL have port decayFactor  input  DECAY_BITS  unsigned decay multiplier, scale 2^DECAY_BITS.
REQ-009 SHALL have port accMet45  input  NUM_STATES*ACS_BITS  45-bank metrics, state k at bits [k*ACS_BITS +: ACS_BITS].
REQ-010 SHALL have port accMet54  input  NUM_STATES*ACS_BITS  54-bank metrics, same packing.
REQ-011 SHALL have port accMuxOut  output  NUM_STATES*ACS_BITS  decayed (optionally normalised) metrics, same packing.
REQ-012 SHALL have port outValid  output  1  one-cycle strobe qualifying accMuxOut.
REQ-013 SHALL have port normEvent  output  1  one-cycle strobe: nonzero normalisation applied (ACS_DECAY_NORM_EN only; tied 0 otherwise).
REQ-014 SHALL have port normCount  output  16  saturating count of normEvent pulses (ACS_DECAY_NORM_EN only; tied 0 otherwise).

Function
REQ-015 Stage 1 SHALL, on symEn=1, register the bank chosen by symEnEven and register decayFactor; symEn=0 leaves stage-1 data unchanged.
REQ-016 decayFactor changes between symEn strobes SHALL NOT affect any in-flight result.
REQ-017 Stage 2 SHALL compute per state d = (m*f + 2^(DECAY_BITS-1)) >> DECAY_BITS, full-width product, round-half-up, truncated to ACS_BITS (no overflow possible since f < 2^DECAY_BITS).
REQ-018 Latched f = 0 SHALL mean bypass: d = m unchanged.
REQ-019 Stage 3 SHALL register the final result onto accMuxOut.
REQ-020 Latency SHALL be exactly 3 clk cycles: symEn in cycle n -> outValid in cycle n+3, independent of configuration.
REQ-021 Fully pipelined: symEn on consecutive cycles SHALL produce outValid on consecutive cycles, no stalls, no drops.
REQ-022 accMuxOut SHALL hold its last value while outValid=0.
REQ-023 All NUM_STATES lanes SHALL be processed identically and in parallel.

Reset
REQ-024 reset=1 SHALL asynchronously clear all pipeline data, valid bits, accMuxOut, outValid, normEvent and normCount to 0.
REQ-025 reset asserted mid-pipeline SHALL discard all in-flight symbols; no outValid for symbols accepted before reset.
REQ-026 First symEn sampled after reset deasserts SHALL produce outValid exactly 3 cycles later.

Configuration
REQ-027 Macro ACS_DECAY_NORM_EN defined: stage 3 SHALL compute mn = min over states of d and output d - mn per state; normEvent=1 with that outValid when mn != 0; normCount increments on each normEvent, saturating at 16'hFFFF.
REQ-028 Macro ACS_DECAY_NORM_EN undefined: stage 3 SHALL pass d unchanged; normEvent and normCount constant 0; no minimum-tree logic.

Verification
REQ-029 Defaults, no macro: symEn=1, symEnEven=1, accMet45 states {200,100,50,1}, decayFactor=128 -> cycle n+3 outValid=1, accMuxOut {100,50,25,1}.
REQ-030 symEnEven=0, accMet54 all 255, decayFactor=0 -> accMuxOut all 255 (bypass); decayFactor=255 -> all 254.
REQ-031 Macro defined: accMet45 {40,30,20,10}, decayFactor=0 -> accMuxOut {30,20,10,0}, normEvent=1, normCount=1; repeat with {9,5,0,7} -> normEvent=0, normCount stays 1.
REQ-032 symEn on 5 consecutive cycles with distinct metrics and decayFactor toggled each cycle -> 5 consecutive outValid, each result using its own latched factor.
REQ-033 Two symEn accepted, reset pulsed 1 cycle later -> no outValid, all outputs 0; symEn after release -> outValid exactly 3 cycles later.
REQ-034 Macro defined, force 65536 normalising symbols -> normCount holds 16'hFFFF, no wrap.

Source files
------------

// File: rtl/acs_decay_mux.sv
// acs_decay_mux: three-stage pipeline that selects an ACS metric bank,
// scales every state metric by a latched decay factor (round-half-up) and
// registers the result. Optional min-normalisation in the last stage is
// enabled by defining the macro ACS_DECAY_NORM_EN.
module acs_decay_mux #(
    parameter int unsigned ACS_BITS   = 8,
    parameter int unsigned NUM_STATES = 4,
    parameter int unsigned DECAY_BITS = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           symEn,
    input  logic                           symEnEven,
    input  logic [DECAY_BITS-1:0]          decayFactor,
    input  logic [NUM_STATES*ACS_BITS-1:0] accMet45,
    input  logic [NUM_STATES*ACS_BITS-1:0] accMet54,
    output logic [NUM_STATES*ACS_BITS-1:0] accMuxOut,
    output logic                           outValid,
    output logic                           normEvent,
    output logic [15:0]                    normCount
);

    localparam int unsigned VEC_W  = NUM_STATES * ACS_BITS;
    localparam int unsigned PROD_W = ACS_BITS + DECAY_BITS;
    localparam int unsigned HALF   = 1 << (DECAY_BITS - 1);

    logic                  s1_valid;
    logic [VEC_W-1:0]      s1_met;
    logic [DECAY_BITS-1:0] s1_fac;
    logic                  s2_valid;
    logic [VEC_W-1:0]      s2_met;
    logic [VEC_W-1:0]      decay_c;
    logic [VEC_W-1:0]      result_c;

    // Scale one metric; a zero factor is a bypass rather than a multiply by 0.
    function automatic logic [ACS_BITS-1:0] lane_decay(
        input logic [ACS_BITS-1:0]   m,
        input logic [DECAY_BITS-1:0] f
    );
        logic [PROD_W-1:0] p;
        p = PROD_W'(m) * PROD_W'(f) + PROD_W'(HALF);
        if (f == '0) begin
            return m;
        end
        return ACS_BITS'(p >> DECAY_BITS);
    endfunction

    // Stage 1: capture the selected bank together with its own decay factor.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_met   <= '0;
            s1_fac   <= '0;
        end else begin
            s1_valid <= symEn;
            if (symEn) begin
                s1_met <= symEnEven ? accMet45 : accMet54;
                s1_fac <= decayFactor;
            end
        end
    end

    // Stage 2 datapath: identical decay on every state lane.
    always_comb begin
        decay_c = '0;
        for (int k = 0; k < NUM_STATES; k++) begin
            decay_c[k*ACS_BITS +: ACS_BITS] =
                lane_decay(s1_met[k*ACS_BITS +: ACS_BITS], s1_fac);
        end
    end

    // Stage 2 register: decayed metrics.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_met   <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_met <= decay_c;
            end
        end
    end

`ifdef ACS_DECAY_NORM_EN
    logic [ACS_BITS-1:0] min_c;

    // Stage 3 datapath: subtract the smallest decayed metric from all lanes.
    always_comb begin
        min_c    = s2_met[ACS_BITS-1:0];
        result_c = '0;
        for (int k = 1; k < NUM_STATES; k++) begin
            if (s2_met[k*ACS_BITS +: ACS_BITS] < min_c) begin
                min_c = s2_met[k*ACS_BITS +: ACS_BITS];
            end
        end
        for (int k = 0; k < NUM_STATES; k++) begin
            result_c[k*ACS_BITS +: ACS_BITS] = s2_met[k*ACS_BITS +: ACS_BITS] - min_c;
        end
    end

    // Normalisation event strobe and saturating event counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            normEvent <= 1'b0;
            normCount <= '0;
        end else begin
            normEvent <= s2_valid && (min_c != '0);
            if (s2_valid && (min_c != '0) && (normCount != 16'hFFFF)) begin
                normCount <= normCount + 16'd1;
            end
        end
    end
`else
    // Stage 3 datapath: pass-through without normalisation.
    always_comb begin
        result_c = s2_met;
    end

    assign normEvent = 1'b0;
    assign normCount = 16'h0000;
`endif

    // Stage 3 register: output holds between valid results.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outValid  <= 1'b0;
            accMuxOut <= '0;
        end else begin
            outValid <= s2_valid;
            if (s2_valid) begin
                accMuxOut <= result_c;
            end
        end
    end

endmodule

// File: tb/tb_acs_decay_mux.sv
// tb_acs_decay_mux: directed vector bench for acs_decay_mux (default
// parameters). Normalisation checks are compiled in with ACS_DECAY_NORM_EN.
module tb_acs_decay_mux;

    logic        clk = 1'b0;
    logic        reset;
    logic        symEn;
    logic        symEnEven;
    logic [7:0]  decayFactor;
    logic [31:0] accMet45;
    logic [31:0] accMet54;
    logic [31:0] accMuxOut;
    logic        outValid;
    logic        normEvent;
    logic [15:0] normCount;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic        even;
        logic [31:0] m45;
        logic [31:0] m54;
        logic [7:0]  f;
        logic [31:0] d;
    } vec_t;

    vec_t tbl [6];

    acs_decay_mux #(
        .ACS_BITS  (8),
        .NUM_STATES(4),
        .DECAY_BITS(8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .symEn      (symEn),
        .symEnEven  (symEnEven),
        .decayFactor(decayFactor),
        .accMet45   (accMet45),
        .accMet54   (accMet54),
        .accMuxOut  (accMuxOut),
        .outValid   (outValid),
        .normEvent  (normEvent),
        .normCount  (normCount)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pk(input logic [7:0] s0, input logic [7:0] s1,
                                       input logic [7:0] s2, input logic [7:0] s3);
        return {s3, s2, s1, s0};
    endfunction

    // Expected output from the hand-computed decayed value.
    function automatic logic [31:0] exp_out(input logic [31:0] d);
`ifdef ACS_DECAY_NORM_EN
        logic [7:0]  mn;
        logic [31:0] r;
        mn = d[7:0];
        for (int k = 1; k < 4; k++) if (d[k*8 +: 8] < mn) mn = d[k*8 +: 8];
        for (int k = 0; k < 4; k++) r[k*8 +: 8] = d[k*8 +: 8] - mn;
        return r;
`else
        return d;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive_sym(input logic even, input logic [31:0] m45,
                             input logic [31:0] m54, input logic [7:0] f);
        symEn       = 1'b1;
        symEnEven   = even;
        accMet45    = m45;
        accMet54    = m54;
        decayFactor = f;
    endtask

    task automatic idle_scramble();
        symEn       = 1'b0;
        symEnEven   = ~symEnEven;
        accMet45    = 32'hA5A5_5A5A;
        accMet54    = 32'h3C3C_C3C3;
        decayFactor = 8'h5A;
    endtask

    initial begin
        // Hand-computed round-half-up decay results (pre-normalisation).
        tbl[0] = '{1'b1, pk(200, 100, 50, 1),   32'h0,               8'd128, pk(100, 50, 25, 1)};
        tbl[1] = '{1'b0, 32'h0,                 32'hFFFF_FFFF,       8'd0,   32'hFFFF_FFFF};
        tbl[2] = '{1'b0, 32'h0,                 32'hFFFF_FFFF,       8'd255, 32'hFEFE_FEFE};
        tbl[3] = '{1'b1, pk(3, 2, 1, 0),        32'h7777_7777,       8'd128, pk(2, 1, 1, 0)};
        tbl[4] = '{1'b0, 32'hAAAA_AAAA,         pk(10, 20, 30, 40),  8'd64,  pk(3, 5, 8, 10)};
        tbl[5] = '{1'b1, pk(255, 128, 127, 64), 32'h1111_1111,       8'd192, pk(191, 96, 95, 48)};

        reset = 1'b1;
        symEn = 1'b0; symEnEven = 1'b0; decayFactor = '0; accMet45 = '0; accMet54 = '0;
        #1;
        check("reset_out",   accMuxOut, 32'h0);
        check("reset_valid", 32'(outValid), 32'h0);
        check("reset_norm",  {15'h0, normEvent, normCount}, 32'h0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;

`ifdef ACS_DECAY_NORM_EN
        // Normalising symbol then one whose minimum is already zero.
        @(negedge clk); drive_sym(1'b1, pk(40, 30, 20, 10), 32'h0, 8'd0);
        @(negedge clk); idle_scramble();
        @(negedge clk); @(negedge clk);
        check("norm1_valid", 32'(outValid), 32'h1);
        check("norm1_out",   accMuxOut, pk(30, 20, 10, 0));
        check("norm1_event", 32'(normEvent), 32'h1);
        check("norm1_count", 32'(normCount), 32'h1);
        @(negedge clk); drive_sym(1'b1, pk(9, 5, 0, 7), 32'h0, 8'd0);
        @(negedge clk); idle_scramble();
        @(negedge clk); @(negedge clk);
        check("norm2_out",   accMuxOut, pk(9, 5, 0, 7));
        check("norm2_event", 32'(normEvent), 32'h0);
        check("norm2_count", 32'(normCount), 32'h1);
`endif

        // Table: single symbols, latency, in-flight factor changes, hold.
        foreach (tbl[i]) begin
            @(negedge clk); drive_sym(tbl[i].even, tbl[i].m45, tbl[i].m54, tbl[i].f);
            @(negedge clk); idle_scramble();
            @(negedge clk);
            check($sformatf("vec%0d_early", i), 32'(outValid), 32'h0);
            @(negedge clk);
            check($sformatf("vec%0d_valid", i), 32'(outValid), 32'h1);
            check($sformatf("vec%0d_out", i),   accMuxOut, exp_out(tbl[i].d));
            @(negedge clk);
            check($sformatf("vec%0d_drop", i),  32'(outValid), 32'h0);
            check($sformatf("vec%0d_hold", i),  accMuxOut, exp_out(tbl[i].d));
        end

        // Back-to-back symbols with the factor toggled every cycle.
        begin
            logic [7:0] bm [5];
            logic [7:0] bd [5];
            bm = '{8'd100, 8'd110, 8'd120, 8'd130, 8'd140};
            bd = '{8'd50,  8'd110, 8'd60,  8'd130, 8'd70};
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                if (k >= 3) begin
                    check($sformatf("burst%0d_valid", k - 3), 32'(outValid), 32'h1);
                    check($sformatf("burst%0d_out", k - 3), accMuxOut,
                          exp_out({4{bd[k-3]}}));
                end
                if (k < 5) drive_sym(1'b1, {4{bm[k]}}, 32'h0, (k % 2 == 0) ? 8'd128 : 8'd0);
                else idle_scramble();
            end
            @(negedge clk);
            check("burst_end", 32'(outValid), 32'h0);
        end

        // Reset while two symbols are in flight.
        @(negedge clk); drive_sym(1'b1, 32'h1020_3040, 32'h0, 8'd0);
        @(negedge clk); drive_sym(1'b1, 32'h5060_7080, 32'h0, 8'd0);
        @(negedge clk); idle_scramble(); reset = 1'b1;
        #1;
        check("rst_mid_out",   accMuxOut, 32'h0);
        check("rst_mid_valid", 32'(outValid), 32'h0);
        check("rst_mid_norm",  {15'h0, normEvent, normCount}, 32'h0);
        @(negedge clk); reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("rst_flush%0d", k), {31'h0, outValid}, 32'h0);
        end
        drive_sym(1'b0, 32'h0, pk(4, 3, 2, 1), 8'd0);
        @(negedge clk); idle_scramble();
        @(negedge clk);
        check("rst_after_early", 32'(outValid), 32'h0);
        @(negedge clk);
        check("rst_after_valid", 32'(outValid), 32'h1);
        check("rst_after_out",   accMuxOut, exp_out(pk(4, 3, 2, 1)));

`ifdef ACS_DECAY_NORM_EN
        // Saturation: 65537 normalising symbols after a fresh reset.
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        for (int k = 0; k < 65537; k++) begin
            @(negedge clk); drive_sym(1'b1, 32'h0101_0101, 32'h0, 8'd0);
        end
        @(negedge clk); idle_scramble();
        repeat (4) @(negedge clk);
        check("sat_count", 32'(normCount), 32'h0000_FFFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
